// File: rtl/tlv5618_rx.sv
// TLV5618 3-wire write-interface responder: captures 16-bit frames and keeps DAC A/B/buffer registers.
// Optional TLV5618_RX_ERRCNT_EN adds a saturating discarded-frame counter on Err_Cnt.
module tlv5618_rx #(
  parameter int FRAME_BITS  = 16,
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              DAC_CS_N,
  input  logic              DAC_SCLK,
  input  logic              DAC_DIN,
  output logic [DATA_W-1:0] DAC_A,
  output logic [DATA_W-1:0] DAC_B,
  output logic [DATA_W-1:0] BUF_DATA,
  output logic              SPD,
  output logic              PWR,
  output logic              Frame_Done,
`ifdef TLV5618_RX_ERRCNT_EN
  output logic              Frame_Err,
  output logic [7:0]        Err_Cnt
`else
  output logic              Frame_Err
`endif
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]  din_sync_q, din_sync_d;
  logic [SYNC_STAGES-1:0]  fill_q, fill_d;
  logic                    cs_prev_q, cs_prev_d;
  logic                    sclk_prev_q, sclk_prev_d;
  logic                    armed_q, armed_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]       dac_a_q, dac_a_d;
  logic [DATA_W-1:0]       dac_b_q, dac_b_d;
  logic [DATA_W-1:0]       buf_q, buf_d;
  logic                    spd_q, spd_d;
  logic                    pwr_q, pwr_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
`ifdef TLV5618_RX_ERRCNT_EN
  logic [7:0]              err_cnt_q, err_cnt_d;
`endif

  logic cs_s, sclk_s, din_s, cs_fall, cs_rise, sclk_fall;
  logic r1, r0;

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], DAC_CS_N};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], DAC_SCLK};
    din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], DAC_DIN};
    fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    din_s       = din_sync_q[SYNC_STAGES-1];
    cs_prev_d   = cs_s;
    sclk_prev_d = sclk_s;
    // A real high CS_N sample must reach the last sync stage before a falling edge may open a frame.
    armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
    cs_fall     = armed_q & cs_prev_q & ~cs_s;
    cs_rise     = ~cs_prev_q & cs_s;
    sclk_fall   = sclk_prev_q & ~sclk_s;
    r1          = shreg_q[FRAME_BITS-1];
    r0          = shreg_q[FRAME_BITS-4];

    state_d = state_q;
    count_d = count_q;
    shreg_d = shreg_q;
    dac_a_d = dac_a_q;
    dac_b_d = dac_b_q;
    buf_d   = buf_q;
    spd_d   = spd_q;
    pwr_d   = pwr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          count_d = '0;
          shreg_d = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          // Outputs and pulse register on the edge that enters COMMIT.
          state_d = COMMIT;
          if (count_q == CNT_W'(FRAME_BITS) && !(r1 && r0)) begin
            unique case ({r1, r0})
              2'b00: begin
                dac_b_d = shreg_q[DATA_W-1:0];
                buf_d   = shreg_q[DATA_W-1:0];
              end
              2'b01: buf_d = shreg_q[DATA_W-1:0];
              default: begin
                dac_a_d = shreg_q[DATA_W-1:0];
                dac_b_d = buf_q;
              end
            endcase
            spd_d  = shreg_q[FRAME_BITS-2];
            pwr_d  = shreg_q[FRAME_BITS-3];
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (sclk_fall) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], din_s};
          if (count_q != CNT_W'(FRAME_BITS + 1)) count_d = count_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef TLV5618_RX_ERRCNT_EN
    err_cnt_d = err_cnt_q;
    if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      cs_sync_q   <= '1;
      sclk_sync_q <= '1;
      din_sync_q  <= '0;
      fill_q      <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
      armed_q     <= 1'b0;
      count_q     <= '0;
      shreg_q     <= '0;
      dac_a_q     <= '0;
      dac_b_q     <= '0;
      buf_q       <= '0;
      spd_q       <= 1'b0;
      pwr_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef TLV5618_RX_ERRCNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      din_sync_q  <= din_sync_d;
      fill_q      <= fill_d;
      cs_prev_q   <= cs_prev_d;
      sclk_prev_q <= sclk_prev_d;
      armed_q     <= armed_d;
      count_q     <= count_d;
      shreg_q     <= shreg_d;
      dac_a_q     <= dac_a_d;
      dac_b_q     <= dac_b_d;
      buf_q       <= buf_d;
      spd_q       <= spd_d;
      pwr_q       <= pwr_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef TLV5618_RX_ERRCNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign DAC_A      = dac_a_q;
  assign DAC_B      = dac_b_q;
  assign BUF_DATA   = buf_q;
  assign SPD        = spd_q;
  assign PWR        = pwr_q;
  assign Frame_Done = done_q;
  assign Frame_Err  = err_q;
`ifdef TLV5618_RX_ERRCNT_EN
  assign Err_Cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_tlv5618_rx.sv
// Scoreboard bench for tlv5618_rx: frames are serialised on the pins, expected commits queued and
// compared when Frame_Done/Frame_Err pulses.
module tb_tlv5618_rx;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        DAC_CS_N, DAC_SCLK, DAC_DIN;
  logic [11:0] DAC_A, DAC_B, BUF_DATA;
  logic        SPD, PWR, Frame_Done, Frame_Err;
`ifdef TLV5618_RX_ERRCNT_EN
  logic [7:0]  Err_Cnt;
`endif

  tlv5618_rx dut (
    .Clk(Clk), .Rst_n(Rst_n), .DAC_CS_N(DAC_CS_N), .DAC_SCLK(DAC_SCLK), .DAC_DIN(DAC_DIN),
    .DAC_A(DAC_A), .DAC_B(DAC_B), .BUF_DATA(BUF_DATA), .SPD(SPD), .PWR(PWR),
`ifdef TLV5618_RX_ERRCNT_EN
    .Frame_Done(Frame_Done), .Frame_Err(Frame_Err), .Err_Cnt(Err_Cnt)
`else
    .Frame_Done(Frame_Done), .Frame_Err(Frame_Err)
`endif
  );

  always #10 Clk = ~Clk;

  typedef struct {
    logic        done;
    logic        err;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] bf;
    logic        spd;
    logic        pwr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          pe_cnt = 0;
  int          rise_edge = 0;
  logic [11:0] m_a, m_b, m_bf;
  logic        m_spd, m_pwr;
  int          m_errs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_a = '0; m_b = '0; m_bf = '0; m_spd = 1'b0; m_pwr = 1'b0; m_errs = 0;
  endtask

  // Reference TLV5618 register behaviour for one frame of n bits.
  task automatic push_exp(input logic [31:0] w, input int n);
    exp_t        e;
    logic [11:0] c;
    logic [1:0]  rr;
    c  = w[11:0];
    rr = {w[15], w[12]};
    e.done = 1'b0;
    e.err  = 1'b0;
    if (n != 16 || rr == 2'b11) begin
      e.err = 1'b1;
      if (m_errs < 255) m_errs++;
    end else begin
      e.done = 1'b1;
      if (rr == 2'b00) begin m_b = c; m_bf = c; end
      else if (rr == 2'b01) m_bf = c;
      else begin m_b = m_bf; m_a = c; end
      m_spd = w[14];
      m_pwr = w[13];
    end
    e.a = m_a; e.b = m_b; e.bf = m_bf; e.spd = m_spd; e.pwr = m_pwr;
    sb_q.push_back(e);
  endtask

  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      DAC_SCLK = 1'b1;
      DAC_DIN  = w[i];
      #100;
      DAC_SCLK = 1'b0;
      #100;
    end
    DAC_SCLK = 1'b1;
  endtask

  task automatic send(input logic [31:0] w, input int n);
    DAC_CS_N = 1'b0;
    #100;
    shift_bits(w, n);
    #100;
    push_exp(w, n);
    DAC_CS_N  = 1'b1;
    rise_edge = pe_cnt;
  endtask

  task automatic settle(input string tag);
    repeat (10) @(negedge Clk);
    chk(tag, sb_q.size(), 0);
  endtask

  task automatic chk_regs(input string tag, input logic [11:0] a, input logic [11:0] b,
                          input logic [11:0] bf, input logic spd, input logic pwr);
    chk({tag, "_a"}, DAC_A, a);
    chk({tag, "_b"}, DAC_B, b);
    chk({tag, "_buf"}, BUF_DATA, bf);
    chk({tag, "_spd"}, SPD, spd);
    chk({tag, "_pwr"}, PWR, pwr);
  endtask

  always @(posedge Clk) pe_cnt <= pe_cnt + 1;

  always @(negedge Clk) begin
    if (Rst_n === 1'b1 && (Frame_Done !== 1'b0 || Frame_Err !== 1'b0)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, Frame_Done, Frame_Err}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pulse_done", Frame_Done, mon_e.done);
        chk("pulse_err", Frame_Err, mon_e.err);
        chk("pulse_latency", pe_cnt - rise_edge, 3);
        chk("commit_a", DAC_A, mon_e.a);
        chk("commit_b", DAC_B, mon_e.b);
        chk("commit_buf", BUF_DATA, mon_e.bf);
        chk("commit_spd", SPD, mon_e.spd);
        chk("commit_pwr", PWR, mon_e.pwr);
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    Rst_n = 1'b0; DAC_CS_N = 1'b1; DAC_SCLK = 1'b1; DAC_DIN = 1'b0;
    model_clear();
    #201 Rst_n = 1'b1;
    @(negedge Clk);
    chk_regs("reset", 12'h000, 12'h000, 12'h000, 1'b0, 1'b0);
    chk("reset_done", Frame_Done, 0);
    chk("reset_err", Frame_Err, 0);
    repeat (10) @(negedge Clk);

    send(32'hCAAA, 16); settle("t1_sb");
    chk_regs("t1", 12'hAAA, 12'h000, 12'h000, 1'b1, 1'b0);

    send(32'h4555, 16); settle("t2_sb");
    chk_regs("t2", 12'hAAA, 12'h555, 12'h555, 1'b1, 1'b0);

    send(32'h1123, 16); settle("t3a_sb");
    chk_regs("t3a", 12'hAAA, 12'h555, 12'h123, 1'b0, 1'b0);
    send(32'h80F0, 16); settle("t3b_sb");
    chk_regs("t3b", 12'h0F0, 12'h123, 12'h123, 1'b0, 1'b0);

    send(32'hF555, 16); settle("t4_rsv_sb");
    send(32'h4ABC, 15); settle("t4_short_sb");
    send(32'h14ABC, 17); settle("t4_long_sb");
    chk_regs("t4", 12'h0F0, 12'h123, 12'h123, 1'b0, 1'b0);
`ifdef TLV5618_RX_ERRCNT_EN
    chk("errcnt_3", Err_Cnt, 3);
`endif

    // Reset mid-frame; CS_N stays low through reset release so no frame may start.
    DAC_CS_N = 1'b0;
    #100;
    shift_bits(32'hCF, 8);
    @(negedge Clk);
    Rst_n = 1'b0;
    model_clear();
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (10) @(negedge Clk);
    chk_regs("t5_rst", 12'h000, 12'h000, 12'h000, 1'b0, 1'b0);
    DAC_CS_N = 1'b1;
    settle("t5_nopulse");
    send(32'h23C3, 16); settle("t5_sb");
    chk_regs("t5", 12'h000, 12'h3C3, 12'h3C3, 1'b0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      w = 32'($urandom_range(0, 16'hFFFF));
      send(w, 16);
      settle("rand_sb");
    end

`ifdef TLV5618_RX_ERRCNT_EN
    for (int k = 0; k < 300; k++) begin
      send(32'h1, 1);
      repeat (5) @(negedge Clk);
    end
    settle("errcnt_sb");
    chk("errcnt_sat", Err_Cnt, 8'hFF);
`endif

    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge Clk);
    chk("final_drain", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
